// File: rtl/bit_serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package bit_serial_sub_pkg;

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_CALC = 2'd1;
    localparam logic [1:0] STATE_DONE = 2'd2;

    localparam int BSS_NBITS_DEFAULT = 8;

    typedef enum logic [1:0] {
        S_IDLE = STATE_IDLE,
        S_CALC = STATE_CALC,
        S_DONE = STATE_DONE
    } bss_state_e;

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor built from primitive gates: d = a - b - bin, bout = borrow.
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic na;
    logic t_nab;
    logic t_nabin;
    logic t_bbin;

    not g_na     (na, a);
    xor g_d      (d, a, b, bin);
    and g_nab    (t_nab, na, b);
    and g_nabin  (t_nabin, na, bin);
    and g_bbin   (t_bbin, b, bin);
    or  g_bout   (bout, t_nab, t_nabin, t_bbin);

endmodule

// File: rtl/bit_serial_subtractor.sv
// Area-minimal unsigned subtractor: one full-subtractor cell walks the operands LSB first,
// one bit per cycle, behind val/rdy input and output streams.
module bit_serial_subtractor
    import bit_serial_sub_pkg::*;
#(
    parameter int NBITS = BSS_NBITS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             istream_val,
    output logic             istream_rdy,
    input  logic [NBITS-1:0] in0,
    input  logic [NBITS-1:0] in1,
    output logic             ostream_val,
    input  logic             ostream_rdy,
    output logic [NBITS-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NBITS - 1);

    bss_state_e       state_q, state_d;
    logic [NBITS-1:0] a_q, a_d;
    logic [NBITS-1:0] b_q, b_d;
    logic [NBITS-1:0] diff_q, diff_d;
    logic             bor_q, bor_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic cell_d;
    logic cell_bout;

    full_subtractor_cell u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (bor_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        bor_d   = bor_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (istream_val) begin
                    a_d     = in0;
                    b_d     = in1;
                    diff_d  = '0;
                    bor_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                // Result bits enter at the MSB so the LSB lands at bit 0 after NBITS shifts.
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                diff_d = {cell_d, diff_q[NBITS-1:1]};
                bor_d  = cell_bout;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (ostream_rdy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            bor_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            bor_q   <= bor_d;
            cnt_q   <= cnt_d;
        end
    end

    assign istream_rdy = (state_q == S_IDLE);
    assign ostream_val = (state_q == S_DONE);
    assign diff        = diff_q;
    assign borrow_out  = bor_q;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Directed bench for bit_serial_subtractor (NBITS=8) with hand-computed expected results.
module tb_bit_serial_subtractor;

    localparam int NBITS = 8;

    logic             clk;
    logic             rst_n;
    logic             istream_val;
    logic             istream_rdy;
    logic [NBITS-1:0] in0;
    logic [NBITS-1:0] in1;
    logic             ostream_val;
    logic             ostream_rdy;
    logic [NBITS-1:0] diff;
    logic             borrow_out;

    int checks = 0;
    int errors = 0;

    bit_serial_subtractor #(.NBITS(NBITS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .in0         (in0),
        .in1         (in1),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy),
        .diff        (diff),
        .borrow_out  (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands and wait (bounded) for the accepting edge.
    task automatic accept(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b, input bit keep_val);
        int n;
        in0 = a;
        in1 = b;
        istream_val = 1'b1;
        n = 0;
        while (istream_rdy !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check("accept_rdy", {31'd0, istream_rdy}, 32'd1);
        tick();
        if (!keep_val) istream_val = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (ostream_val !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check("val_seen", {31'd0, ostream_val}, 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [NBITS-1:0] d, input logic b);
        check({tag, "_diff"}, {24'd0, diff}, {24'd0, d});
        check({tag, "_bor"}, {31'd0, borrow_out}, {31'd0, b});
        check({tag, "_irdy"}, {31'd0, istream_rdy}, 32'd0);
    endtask

    task automatic release_out(input string tag);
        ostream_rdy = 1'b1;
        tick();
        ostream_rdy = 1'b0;
        check({tag, "_val_drop"}, {31'd0, ostream_val}, 32'd0);
        check({tag, "_rdy_back"}, {31'd0, istream_rdy}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [NBITS-1:0] a, input logic [NBITS-1:0] b,
                          input logic [NBITS-1:0] d, input logic bo);
        int n;
        accept(a, b, 1'b0);
        wait_done(n);
        check_result(tag, d, bo);
        release_out(tag);
    endtask

    initial begin
        int n;
        rst_n       = 1'b0;
        istream_val = 1'b0;
        ostream_rdy = 1'b0;
        in0         = '0;
        in1         = '0;
        #12;
        check("rst_irdy", {31'd0, istream_rdy}, 32'd1);
        check("rst_oval", {31'd0, ostream_val}, 32'd0);
        check("rst_diff", {24'd0, diff}, 32'd0);
        check("rst_bor", {31'd0, borrow_out}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // 5 - 3 with latency: valid appears NBITS edges after the accept edge.
        accept(8'd5, 8'd3, 1'b0);
        wait_done(n);
        check("lat_5m3", n, NBITS);
        check_result("r_5m3", 8'h02, 1'b0);
        release_out("r_5m3");

        run_op("r_3m5", 8'd3, 8'd5, 8'hFE, 1'b1);
        run_op("r_0m1", 8'h00, 8'h01, 8'hFF, 1'b1);
        run_op("r_a5ma5", 8'hA5, 8'hA5, 8'h00, 1'b0);
        run_op("r_ffm0", 8'hFF, 8'h00, 8'hFF, 1'b0);

        // Back-pressure: outputs hold, no accept while DONE even with new operands offered.
        accept(8'h40, 8'h41, 1'b0);
        wait_done(n);
        in0 = 8'h77;
        in1 = 8'h22;
        istream_val = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_diff", {24'd0, diff}, 32'hFF);
            check("bp_bor", {31'd0, borrow_out}, 32'd1);
            check("bp_irdy", {31'd0, istream_rdy}, 32'd0);
            check("bp_oval", {31'd0, ostream_val}, 32'd1);
            tick();
        end
        release_out("bp");
        tick();
        istream_val = 1'b0;
        wait_done(n);
        check_result("bp_next", 8'h55, 1'b0);
        release_out("bp_next");

        // Operand churn during CALC with istream_val held high.
        accept(8'h5A, 8'h3C, 1'b1);
        for (int i = 0; i < NBITS; i++) begin
            in0 = 8'($urandom);
            in1 = 8'($urandom);
            check("churn_irdy", {31'd0, istream_rdy}, 32'd0);
            tick();
        end
        check_result("churn", 8'h1E, 1'b0);
        in0 = 8'h10;
        in1 = 8'h20;
        release_out("churn");
        tick();
        istream_val = 1'b0;
        wait_done(n);
        check_result("churn_next", 8'hF0, 1'b1);
        release_out("churn_next");

        // Asynchronous reset in the middle of CALC.
        accept(8'd9, 8'd4, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_irdy", {31'd0, istream_rdy}, 32'd1);
        check("ar_oval", {31'd0, ostream_val}, 32'd0);
        check("ar_diff", {24'd0, diff}, 32'd0);
        check("ar_bor", {31'd0, borrow_out}, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            check("ar_no_stale", {31'd0, ostream_val}, 32'd0);
            tick();
        end
        run_op("ar_9m4", 8'd9, 8'd4, 8'h05, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_serial_subtractor.md
# bit_serial_subtractor

Multi-cycle unsigned subtractor computing `in0 - in1` one bit per cycle, LSB first, using a single one-bit full-subtractor cell and a borrow register. It sits behind the lab's ripple adder datapaths as the area-minimal counterpart: it consumes operands over a val/rdy input stream and produces the difference plus final borrow over a val/rdy output stream. It is used where throughput is irrelevant but gate count matters.

## Interface
- `NBITS`, default 8: operand and result width; legal range ≥ 2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `istream_val` input 1: operands valid.
- `istream_rdy` output 1: block can accept operands.
- `in0` input NBITS: minuend.
- `in1` input NBITS: subtrahend.
- `ostream_val` output 1: result valid.
- `ostream_rdy` input 1: consumer accepts the result.
- `diff` output NBITS: `(in0 - in1) mod 2^NBITS`.
- `borrow_out` output 1: 1 iff `in0 < in1` (unsigned).

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - `istream_rdy`=1; `ostream_val`=0.
  - On `istream_val & istream_rdy`: latch `in0` and `in1` into shift registers `a_q` and `b_q`; clear `diff_q`, borrow register `bor_q`=0, and bit counter `cnt_q`=0; go to CALC.
- CALC:
  - `istream_rdy`=0 and `ostream_val`=0.
  - Each cycle the cell takes `a=a_q[0]`, `b=b_q[0]`, `bin=bor_q` and computes `d = a^b^bin` and `bout = (~a&b) | (~a&bin) | (b&bin)`.
  - `a_q` and `b_q` shift right by one.
  - `diff_q` shifts right by one with `d` inserted at MSB.
  - `bor_q` takes `bout`; `cnt_q` increments.
  - When `cnt_q == NBITS-1`, go to DONE after that cycle's update.
- DONE:
  - `ostream_val`=1; `diff`=`diff_q`; `borrow_out`=`bor_q`.
  - Outputs stay stable while `ostream_rdy`=0.
  - On `ostream_val & ostream_rdy`: go to IDLE.
- Operand ports are ignored outside the IDLE accept cycle; changes during CALC or DONE have no effect.
- Width rules:
  - `cnt_q` is `$clog2(NBITS)` bits wide.
  - `diff` wraps modulo 2^NBITS.
  - No signed interpretation; `borrow_out` is the unsigned underflow flag.
- Outputs are driven combinationally from state and registers only; there is no input→output combinational path.

## Timing
- Reset (`rst_n`=0, asynchronous, any state) immediately forces:
  - state=IDLE;
  - `a_q`, `b_q`, `diff_q`, `bor_q`, `cnt_q` all = 0;
  - `istream_rdy`=1, `ostream_val`=0, `diff`=0, `borrow_out`=0.
- Reset mid-CALC or mid-DONE discards the operation. Nothing is emitted after deassertion.
- Operands are accepted at edge E. `ostream_val` rises after edge E+NBITS, giving a latency of NBITS+1 cycles from the accept cycle to the first valid cycle.
- `istream_rdy` returns to 1 in the cycle after the output handshake edge, so there is no same-cycle accept during DONE.
- Throughput: at most one operation per NBITS+2 cycles with `ostream_rdy` held at 1.
- Initiation is blocked while busy; `istream_val` in CALC or DONE is held by the producer, per val/rdy rules.

## Structure
- Shared header/package `bit_serial_sub_pkg`:
  - state encoding localparams: `STATE_IDLE`=2'd0, `STATE_CALC`=2'd1, `STATE_DONE`=2'd2;
  - default width `BSS_NBITS_DEFAULT`=8.
- One sub-module, `full_subtractor_cell`:
  - gate-level, purely combinational;
  - ports `a`, `b`, `bin`, `d`, `bout`;
  - instantiated once.
- The top level contains the FSM, counter, and the three shift registers and borrow register.

## Test plan
All scenarios use NBITS=8.
- Accept `in0`=5, `in1`=3 → `ostream_val` high exactly 9 cycles after accept; `diff`=0x02, `borrow_out`=0.
- `in0`=3, `in1`=5 → `diff`=0xFE, `borrow_out`=1. Also `in0`=0x00, `in1`=0x01 → `diff`=0xFF, `borrow_out`=1.
- `in0`=0xA5, `in1`=0xA5 → `diff`=0x00, `borrow_out`=0. Also `in0`=0xFF, `in1`=0x00 → `diff`=0xFF, `borrow_out`=0.
- Back-pressure: hold `ostream_rdy`=0 for 5 cycles in DONE → `diff` and `borrow_out` unchanged and `istream_rdy`=0 throughout; the first accept after release takes the new operands.
- During CALC, toggle `in0`/`in1` and hold `istream_val`=1 → result still matches the latched operands; no second accept until IDLE.
- Assert `rst_n`=0 at CALC cycle 4 of `in0`=9, `in1`=4 → outputs are at reset values immediately (before the next clock edge). After release, run `in0`=9, `in1`=4 → `diff`=0x05, `borrow_out`=0, with no stale result emitted.
